uart_rx_frame_parser: RTL and testbench
=======================================

Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of uart_rx and consumes its per-byte event/data stream.
- Delimits frames of the form SOF0, SOF1, LEN, PAYLOAD[LEN], CHK and checks their length and checksum.
- Holds the payload in an internal buffer. A payload is released on a valid/ready byte stream only after the frame's checksum passes.
- Reports checksum, length, inter-byte timeout and overrun errors as single-cycle pulses, and keeps a count of good frames.

Parameters:
MAIN_CLK_RATE, 32'd100_000_000, mclk frequency in Hz
BAUD_CLK_RATE, 32'd115200, UART baud rate
MAX_LEN, 64, maximum payload bytes (1..255); sets buffer depth
TIMEOUT_BYTES, 4, permitted inter-byte gap in byte times; TMO_CYC = TIMEOUT_BYTES*10*MAIN_CLK_RATE/BAUD_CLK_RATE
SOF0, 8'h55, first start-of-frame byte
SOF1, 8'hAA, second start-of-frame byte

Ports:
mclk  input  1  system clock; all logic on rising edge
mrst_n  input  1  asynchronous active-low reset
uart_rx_evt_i  input  1  one-cycle strobe: uart_rx_data_i holds a new byte
uart_rx_data_i  input  8  received byte
frm_data_o  output  8  payload byte
frm_valid_o  output  1  frm_data_o valid
frm_last_o  output  1  current byte is the last payload byte
frm_ready_i  input  1  downstream accepts the byte
frm_len_o  output  8  LEN of the frame being drained; stable for the whole drain
frm_busy_o  output  1  high in any state other than IDLE
chk_err_o  output  1  one-cycle pulse: checksum mismatch
len_err_o  output  1  one-cycle pulse: LEN==0 or LEN>MAX_LEN
tmo_err_o  output  1  one-cycle pulse: inter-byte timeout
drop_err_o  output  1  one-cycle pulse: byte received during DRAIN and discarded
frm_cnt_o  output  16  count of good frames; wraps 16'hFFFF->0

Behaviour:
- Reset (mrst_n low, asynchronous): state=IDLE, all outputs 0, pointers, checksum and timer cleared. A reset mid-frame or mid-drain abandons the frame immediately with no error pulse.
- Byte acceptance: only on cycles with uart_rx_evt_i=1.
- States:
  - IDLE: byte==SOF0 -> S_SOF1; any other byte is ignored.
  - S_SOF1: byte==SOF1 -> S_LEN; byte==SOF0 stays in S_SOF1 (resync); any other byte -> IDLE.
  - S_LEN: LEN==0 or LEN>MAX_LEN -> len_err_o pulse, then IDLE. Otherwise latch LEN, set sum=LEN, wr_ptr=0, go to S_PAY.
  - S_PAY: write byte to buf[wr_ptr], sum+=byte (mod 256), wr_ptr++. On the LEN-th byte -> S_CHK.
  - S_CHK: byte==sum -> frm_cnt_o++, rd_ptr=0, go to DRAIN. Otherwise chk_err_o pulse, go to IDLE; buffer content is never output.
  - DRAIN: present buf[rd_ptr].
- Drain latency: frm_valid_o rises on the 1st cycle after the CHK byte is accepted.
- Handshake:
  - A transfer occurs when frm_valid_o & frm_ready_i are both high.
  - While frm_ready_i=0, frm_data_o and frm_last_o hold stable and frm_valid_o stays high.
  - When frm_ready_i stays high, consecutive bytes go out one per cycle.
  - frm_last_o=1 exactly when rd_ptr==LEN-1.
  - A transfer with frm_last_o=1 -> frm_valid_o=0 next cycle, state=IDLE.
- Overrun: uart_rx_evt_i during DRAIN -> drop_err_o pulse and the byte is discarded, including SOF0.
- Timeout:
  - The timer is active in S_SOF1, S_LEN, S_PAY and S_CHK.
  - It reloads on each accepted byte and counts mclk cycles.
  - Reaching TMO_CYC -> tmo_err_o pulse, then IDLE.
  - The timer is inactive in IDLE and DRAIN.
  - If a byte arrives in the same cycle the timer expires, the byte wins and the timer reloads.
- Error pulses are mutually exclusive and last exactly 1 cycle.
- Widths: sum is 8-bit wrapping; pointers are clog2(MAX_LEN) bits wide plus 1.

Test Plan:
- Good frame: rx 55 AA 03 11 22 33 69 with frm_ready_i=1 -> frm_valid_o high for 3 cycles starting 1 cycle after 69; data 11,22,33; frm_last_o on 33; frm_len_o=3; frm_cnt_o=1; no error pulses.
- Checksum error: rx 55 AA 02 01 02 00 -> one chk_err_o pulse, frm_valid_o never high, frm_cnt_o unchanged. A following good frame is accepted.
- Length error: rx 55 AA 00, and separately 55 AA 41 (65 > MAX_LEN) -> len_err_o pulse each time, back to IDLE. The next good frame is accepted.
- Timeout: rx 55 AA 04 01, then no events for TMO_CYC cycles -> one tmo_err_o pulse exactly TMO_CYC cycles after 01, frm_busy_o=0. No pulse if the next byte arrives at TMO_CYC-1.
- Backpressure/overrun: good 4-byte frame with frm_ready_i toggling 1,0,0,1,... -> data held stable while ready=0, all 4 bytes delivered once in order. An rx byte injected during DRAIN -> drop_err_o pulse, output stream unaffected.
- Resync/reset: rx 55 55 AA 01 7E 7F -> frame accepted with payload 7E. Assert mrst_n low mid-payload -> all outputs 0 immediately; after release a good frame is parsed normally.

Source files
------------

// File: rtl/uart_rx_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_parser
//
// Purpose:
//   Consumes the per-byte event/data stream of a UART receiver and delimits
//   frames of the form SOF0, SOF1, LEN, PAYLOAD[LEN], CHK. The payload is
//   buffered internally and only released on a valid/ready byte stream once
//   the frame checksum (LEN + sum of payload, mod 256) matches CHK.
//   Checksum, length, inter-byte timeout and overrun errors are reported as
//   mutually exclusive single-cycle pulses; good frames are counted.
//
// Ports:
//   mclk            system clock, all logic on the rising edge
//   mrst_n          asynchronous active-low reset
//   uart_rx_evt_i   one-cycle strobe, uart_rx_data_i holds a new byte
//   uart_rx_data_i  received byte
//   frm_data_o      payload byte (0 while frm_valid_o is low)
//   frm_valid_o     frm_data_o valid
//   frm_last_o      current byte is the last payload byte
//   frm_ready_i     downstream accepts the byte
//   frm_len_o       LEN of the frame being drained, stable during the drain
//   frm_busy_o      parser is in any state other than IDLE
//   chk_err_o       pulse: checksum mismatch
//   len_err_o       pulse: LEN == 0 or LEN > MAX_LEN
//   tmo_err_o       pulse: inter-byte timeout
//   drop_err_o      pulse: byte received while draining, discarded
//   frm_cnt_o       good-frame counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module uart_rx_frame_parser #(
  parameter logic [31:0] MAIN_CLK_RATE = 32'd100_000_000,
  parameter logic [31:0] BAUD_CLK_RATE = 32'd115200,
  parameter int          MAX_LEN       = 64,
  parameter int          TIMEOUT_BYTES = 4,
  parameter logic [7:0]  SOF0          = 8'h55,
  parameter logic [7:0]  SOF1          = 8'hAA
) (
  input  logic        mclk,
  input  logic        mrst_n,
  input  logic        uart_rx_evt_i,
  input  logic [7:0]  uart_rx_data_i,
  output logic [7:0]  frm_data_o,
  output logic        frm_valid_o,
  output logic        frm_last_o,
  input  logic        frm_ready_i,
  output logic [7:0]  frm_len_o,
  output logic        frm_busy_o,
  output logic        chk_err_o,
  output logic        len_err_o,
  output logic        tmo_err_o,
  output logic        drop_err_o,
  output logic [15:0] frm_cnt_o
);

  localparam int PTR_W = $clog2(MAX_LEN) + 1;
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // 10 bit times per UART byte; computed in 64 bits so large clock rates
  // do not overflow. Clamped to at least one cycle.
  localparam longint TMO_CYC_L = (longint'(TIMEOUT_BYTES) * 10 * longint'(MAIN_CLK_RATE))
                                 / longint'(BAUD_CLK_RATE);
  localparam longint TMO_CYC_C = (TMO_CYC_L < 1) ? 1 : TMO_CYC_L;
  localparam int     TMO_W     = $clog2(TMO_CYC_C + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC_C - 1);

  localparam logic [8:0] MAX_LEN_V = 9'(MAX_LEN);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SOF1  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_PAY   = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  logic [2:0]       state_reg,    state_next;
  logic [7:0]       len_reg,      len_next;
  logic [7:0]       sum_reg,      sum_next;
  logic [PTR_W-1:0] wr_ptr_reg,   wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg,   rd_ptr_next;
  logic [TMO_W-1:0] timer_reg,    timer_next;
  logic             valid_reg,    valid_next;
  logic             last_reg,     last_next;
  logic [15:0]      cnt_reg,      cnt_next;
  logic             chk_err_reg,  chk_err_next;
  logic             len_err_reg,  len_err_next;
  logic             tmo_err_reg,  tmo_err_next;
  logic             drop_err_reg, drop_err_next;

  // Payload buffer: plain array with registered, enabled read so it maps
  // onto block RAM. The read register doubles as the output data register.
  logic [7:0]       pay_mem [0:MAX_LEN-1];
  logic [7:0]       rd_data_reg;
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             timer_active;
  logic             tmo_hit;

  assign wr_ptr_inc   = wr_ptr_reg + PTR_W'(1);
  assign rd_ptr_inc   = rd_ptr_reg + PTR_W'(1);
  assign timer_active = (state_reg == ST_SOF1) || (state_reg == ST_LEN) ||
                        (state_reg == ST_PAY)  || (state_reg == ST_CHK);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit      = timer_active && !uart_rx_evt_i && (timer_reg == TMO_LAST);

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    sum_next      = sum_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    valid_next    = valid_reg;
    last_next     = last_reg;
    cnt_next      = cnt_reg;
    chk_err_next  = 1'b0;
    len_err_next  = 1'b0;
    tmo_err_next  = 1'b0;
    drop_err_next = 1'b0;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    wr_addr       = wr_ptr_reg[AW-1:0];
    rd_addr       = '0;
    // Timer restarts on every accepted byte and idles at zero outside the
    // frame-collection states.
    timer_next    = (timer_active && !uart_rx_evt_i) ? timer_reg + TMO_W'(1) : '0;

    case (state_reg)
      ST_IDLE: begin
        if (uart_rx_evt_i && uart_rx_data_i == SOF0) state_next = ST_SOF1;
      end
      ST_SOF1: begin
        if (uart_rx_evt_i) begin
          if (uart_rx_data_i == SOF1)      state_next = ST_LEN;
          else if (uart_rx_data_i == SOF0) state_next = ST_SOF1;
          else                             state_next = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (uart_rx_evt_i) begin
          if (uart_rx_data_i == 8'd0 || {1'b0, uart_rx_data_i} > MAX_LEN_V) begin
            len_err_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            len_next    = uart_rx_data_i;
            sum_next    = uart_rx_data_i;
            wr_ptr_next = '0;
            state_next  = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (uart_rx_evt_i) begin
          wr_en       = 1'b1;
          sum_next    = sum_reg + uart_rx_data_i;
          wr_ptr_next = wr_ptr_inc;
          if (9'(wr_ptr_inc) == {1'b0, len_reg}) state_next = ST_CHK;
        end
      end
      ST_CHK: begin
        if (uart_rx_evt_i) begin
          if (uart_rx_data_i == sum_reg) begin
            // Prefetch the first payload byte so valid rises on the very
            // next cycle with data already in place.
            cnt_next    = cnt_reg + 16'd1;
            rd_ptr_next = '0;
            rd_en       = 1'b1;
            rd_addr     = '0;
            valid_next  = 1'b1;
            last_next   = (len_reg == 8'd1);
            state_next  = ST_DRAIN;
          end else begin
            chk_err_next = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (uart_rx_evt_i) drop_err_next = 1'b1;
        if (valid_reg && frm_ready_i) begin
          if (last_reg) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            rd_ptr_next = rd_ptr_inc;
            rd_en       = 1'b1;
            rd_addr     = rd_ptr_inc[AW-1:0];
            last_next   = (9'(rd_ptr_inc) + 9'd1 == {1'b0, len_reg});
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (tmo_hit) begin
      tmo_err_next = 1'b1;
      timer_next   = '0;
      state_next   = ST_IDLE;
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      sum_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      timer_reg    <= '0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      cnt_reg      <= '0;
      chk_err_reg  <= 1'b0;
      len_err_reg  <= 1'b0;
      tmo_err_reg  <= 1'b0;
      drop_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      sum_reg      <= sum_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      timer_reg    <= timer_next;
      valid_reg    <= valid_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      chk_err_reg  <= chk_err_next;
      len_err_reg  <= len_err_next;
      tmo_err_reg  <= tmo_err_next;
      drop_err_reg <= drop_err_next;
    end
  end

  // No reset on the buffer; stale contents are masked by valid_reg.
  always_ff @(posedge mclk) begin
    if (wr_en) pay_mem[wr_addr] <= uart_rx_data_i;
    if (rd_en) rd_data_reg <= pay_mem[rd_addr];
  end

  assign frm_data_o  = valid_reg ? rd_data_reg : 8'h00;
  assign frm_valid_o = valid_reg;
  assign frm_last_o  = last_reg;
  assign frm_len_o   = len_reg;
  assign frm_busy_o  = (state_reg != ST_IDLE);
  assign chk_err_o   = chk_err_reg;
  assign len_err_o   = len_err_reg;
  assign tmo_err_o   = tmo_err_reg;
  assign drop_err_o  = drop_err_reg;
  assign frm_cnt_o   = cnt_reg;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_parser
//
// Self-checking bench. Expected payload bytes are pushed to a scoreboard queue
// when a good frame is driven and popped by a monitor thread whenever the DUT
// completes a valid/ready transfer. Clock rate is scaled down so the inter-
// byte timeout is 400 cycles.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_parser;

  localparam logic [31:0] MCLK_HZ = 32'd1_152_000;
  localparam logic [31:0] BAUD_HZ = 32'd115200;
  localparam int          MAX_LEN = 64;
  localparam int          TMO_CYC = 4 * 10 * 1152000 / 115200;

  logic        mclk = 1'b0;
  logic        mrst_n = 1'b0;
  logic        uart_rx_evt_i = 1'b0;
  logic [7:0]  uart_rx_data_i = 8'h00;
  logic [7:0]  frm_data_o;
  logic        frm_valid_o;
  logic        frm_last_o;
  logic        frm_ready_i = 1'b1;
  logic [7:0]  frm_len_o;
  logic        frm_busy_o;
  logic        chk_err_o;
  logic        len_err_o;
  logic        tmo_err_o;
  logic        drop_err_o;
  logic [15:0] frm_cnt_o;

  uart_rx_frame_parser #(
    .MAIN_CLK_RATE (MCLK_HZ),
    .BAUD_CLK_RATE (BAUD_HZ),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_BYTES (4),
    .SOF0          (8'h55),
    .SOF1          (8'hAA)
  ) dut (
    .mclk           (mclk),
    .mrst_n         (mrst_n),
    .uart_rx_evt_i  (uart_rx_evt_i),
    .uart_rx_data_i (uart_rx_data_i),
    .frm_data_o     (frm_data_o),
    .frm_valid_o    (frm_valid_o),
    .frm_last_o     (frm_last_o),
    .frm_ready_i    (frm_ready_i),
    .frm_len_o      (frm_len_o),
    .frm_busy_o     (frm_busy_o),
    .chk_err_o      (chk_err_o),
    .len_err_o      (len_err_o),
    .tmo_err_o      (tmo_err_o),
    .drop_err_o     (drop_err_o),
    .frm_cnt_o      (frm_cnt_o)
  );

  always #5 mclk = ~mclk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_cnt = 0;

  // Error pulse counters (cycles high) maintained by the monitor thread.
  int n_chk = 0, n_len = 0, n_tmo = 0, n_drop = 0, n_multi = 0;
  int s_chk = 0, s_len = 0, s_tmo = 0, s_drop = 0, s_multi = 0;

  logic [8:0] sb_q[$];
  logic [7:0] pl [0:63];
  int         pl_n = 0;

  logic       hold_pending = 1'b0;
  logic [8:0] hold_val = '0;

  function automatic logic [39:0] err_delta();
    return {8'(n_chk - s_chk), 8'(n_len - s_len), 8'(n_tmo - s_tmo),
            8'(n_drop - s_drop), 8'(n_multi - s_multi)};
  endfunction

  task automatic snap();
    s_chk = n_chk; s_len = n_len; s_tmo = n_tmo; s_drop = n_drop; s_multi = n_multi;
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send(input logic [7:0] b);
    uart_rx_evt_i  = 1'b1;
    uart_rx_data_i = b;
    @(negedge mclk);
    uart_rx_evt_i  = 1'b0;
  endtask

  // Sends SOF0 SOF1 LEN PAYLOAD CHK from pl/pl_n; chk_xor != 0 corrupts CHK.
  task automatic send_frame(input logic [7:0] chk_xor);
    logic [7:0] chk;
    chk = 8'(pl_n);
    for (int i = 0; i < pl_n; i++) chk = chk + pl[i];
    if (chk_xor == 8'h00)
      for (int i = 0; i < pl_n; i++) sb_q.push_back({(i == pl_n - 1), pl[i]});
    send(8'h55);
    send(8'hAA);
    send(8'(pl_n));
    for (int i = 0; i < pl_n; i++) send(pl[i]);
    send(chk ^ chk_xor);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge mclk);
      #1;
      if (!mrst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (chk_err_o)  n_chk++;
        if (len_err_o)  n_len++;
        if (tmo_err_o)  n_tmo++;
        if (drop_err_o) n_drop++;
        if (int'(chk_err_o) + int'(len_err_o) + int'(tmo_err_o) + int'(drop_err_o) > 1) n_multi++;
        if (hold_pending) begin
          total_cnt++;
          if (frm_valid_o !== 1'b1 || {frm_last_o, frm_data_o} !== hold_val)
            $display("FAIL hold: got v=%b last/data=%h expected v=1 last/data=%h",
                     frm_valid_o, {frm_last_o, frm_data_o}, hold_val);
          else pass_cnt++;
        end
        hold_pending = frm_valid_o && !frm_ready_i;
        hold_val     = {frm_last_o, frm_data_o};
        if (frm_valid_o && frm_ready_i) begin
          total_cnt++;
          if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: got last/data=%h expected no output",
                     {frm_last_o, frm_data_o});
          end else begin
            logic [8:0] exp;
            exp = sb_q.pop_front();
            if ({frm_last_o, frm_data_o} !== exp)
              $display("FAIL sb_data: got last/data=%h expected %h", {frm_last_o, frm_data_o}, exp);
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [38:0] outs;
    mrst_n = 1'b0;
    @(negedge mclk);
    outs = {frm_data_o, frm_valid_o, frm_last_o, frm_len_o, frm_busy_o, chk_err_o,
            len_err_o, tmo_err_o, drop_err_o, frm_cnt_o};
    total_cnt++;
    if (outs !== '0) $display("FAIL reset_outs: got %h expected 0", outs);
    else pass_cnt++;
    repeat (2) @(negedge mclk);
    mrst_n  = 1'b1;
    exp_cnt = 0;
    @(negedge mclk);
  endtask

  task automatic test_good_frame();
    int  high;
    logic len_bad;
    snap();
    sb_q.push_back({1'b0, 8'h11});
    sb_q.push_back({1'b0, 8'h22});
    sb_q.push_back({1'b1, 8'h33});
    send(8'h55); send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    total_cnt++;
    if (frm_valid_o !== 1'b0) $display("FAIL good_valid_early: got %b expected 0", frm_valid_o);
    else pass_cnt++;
    send(8'h69);
    exp_cnt++;
    total_cnt++;
    if (frm_valid_o !== 1'b1) $display("FAIL good_valid_latency: got %b expected 1", frm_valid_o);
    else pass_cnt++;
    high = 0;
    len_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (frm_valid_o) begin
        high++;
        if (frm_len_o !== 8'd3) len_bad = 1'b1;
      end
      @(negedge mclk);
    end
    total_cnt++;
    if (high != 3) $display("FAIL good_valid_cycles: got %0d expected 3", high);
    else pass_cnt++;
    total_cnt++;
    if (len_bad) $display("FAIL good_len: got %0d expected 3", frm_len_o);
    else pass_cnt++;
    total_cnt++;
    if (frm_cnt_o !== 16'(exp_cnt)) $display("FAIL good_cnt: got %0d expected %0d", frm_cnt_o, exp_cnt);
    else pass_cnt++;
    #2;
    total_cnt++;
    if (err_delta() !== 40'h0) $display("FAIL good_errs: got %h expected 0", err_delta());
    else pass_cnt++;
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL good_sb_left: got %0d expected 0", sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_chk_error();
    snap();
    send(8'h55); send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    repeat (6) @(negedge mclk);
    #2;
    total_cnt++;
    if (err_delta() !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0})
      $display("FAIL chk_errs: got %h expected 0100000000", err_delta());
    else pass_cnt++;
    total_cnt++;
    if (frm_cnt_o !== 16'(exp_cnt) || frm_busy_o !== 1'b0)
      $display("FAIL chk_cnt_busy: got cnt=%0d busy=%b expected cnt=%0d busy=0", frm_cnt_o, frm_busy_o, exp_cnt);
    else pass_cnt++;
    pl[0] = 8'hA5; pl_n = 1;
    send_frame(8'h00);
    exp_cnt++;
    repeat (6) @(negedge mclk);
    #2;
    total_cnt++;
    if (frm_cnt_o !== 16'(exp_cnt) || sb_q.size() != 0)
      $display("FAIL chk_recover: got cnt=%0d left=%0d expected cnt=%0d left=0", frm_cnt_o, sb_q.size(), exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_len_error();
    snap();
    send(8'h55); send(8'hAA); send(8'h00);
    total_cnt++;
    if (len_err_o !== 1'b1 || frm_busy_o !== 1'b0)
      $display("FAIL len_zero: got err=%b busy=%b expected err=1 busy=0", len_err_o, frm_busy_o);
    else pass_cnt++;
    send(8'h55); send(8'hAA); send(8'h41);
    total_cnt++;
    if (len_err_o !== 1'b1 || frm_busy_o !== 1'b0)
      $display("FAIL len_big: got err=%b busy=%b expected err=1 busy=0", len_err_o, frm_busy_o);
    else pass_cnt++;
    repeat (3) @(negedge mclk);
    #2;
    total_cnt++;
    if (err_delta() !== {8'd0, 8'd2, 8'd0, 8'd0, 8'd0})
      $display("FAIL len_errs: got %h expected 0002000000", err_delta());
    else pass_cnt++;
    // LEN == MAX_LEN is the largest legal frame.
    pl_n = MAX_LEN;
    for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'(i * 7 + 1);
    send_frame(8'h00);
    exp_cnt++;
    repeat (80) @(negedge mclk);
    #2;
    total_cnt++;
    if (frm_cnt_o !== 16'(exp_cnt) || sb_q.size() != 0 || frm_busy_o !== 1'b0)
      $display("FAIL len_max_frame: got cnt=%0d left=%0d busy=%b expected cnt=%0d left=0 busy=0",
               frm_cnt_o, sb_q.size(), frm_busy_o, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic early;
    snap();
    send(8'h55); send(8'hAA); send(8'h04); send(8'h01);
    early = 1'b0;
    for (int k = 1; k <= TMO_CYC; k++) begin
      @(negedge mclk);
      if (k < TMO_CYC && tmo_err_o) early = 1'b1;
    end
    total_cnt++;
    if (tmo_err_o !== 1'b1 || early)
      $display("FAIL tmo_pulse_time: got pulse=%b early=%b expected pulse=1 early=0", tmo_err_o, early);
    else pass_cnt++;
    total_cnt++;
    if (frm_busy_o !== 1'b0) $display("FAIL tmo_busy: got %b expected 0", frm_busy_o);
    else pass_cnt++;
    repeat (3) @(negedge mclk);
    #2;
    total_cnt++;
    if (err_delta() !== {8'd0, 8'd0, 8'd1, 8'd0, 8'd0})
      $display("FAIL tmo_errs: got %h expected 0000010000", err_delta());
    else pass_cnt++;
    // Byte arriving in the expiry cycle must win.
    @(negedge mclk);
    snap();
    sb_q.push_back({1'b0, 8'h01});
    sb_q.push_back({1'b1, 8'h02});
    send(8'h55); send(8'hAA); send(8'h02); send(8'h01);
    repeat (TMO_CYC - 1) @(negedge mclk);
    send(8'h02);
    send(8'h05);
    exp_cnt++;
    repeat (6) @(negedge mclk);
    #2;
    total_cnt++;
    if (err_delta() !== 40'h0 || frm_cnt_o !== 16'(exp_cnt) || sb_q.size() != 0)
      $display("FAIL tmo_boundary: got errs=%h cnt=%0d left=%0d expected errs=0 cnt=%0d left=0",
               err_delta(), frm_cnt_o, sb_q.size(), exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    @(negedge mclk);
    snap();
    pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF; pl_n = 4;
    send_frame(8'h00);
    exp_cnt++;
    for (int i = 0; i < 20; i++) begin
      frm_ready_i    = (i % 4 == 0) || (i % 4 == 3);
      uart_rx_evt_i  = (i == 2);
      uart_rx_data_i = 8'h55;
      @(negedge mclk);
    end
    uart_rx_evt_i = 1'b0;
    frm_ready_i   = 1'b1;
    #2;
    total_cnt++;
    if (err_delta() !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd0})
      $display("FAIL bp_drop: got %h expected 0000000100", err_delta());
    else pass_cnt++;
    total_cnt++;
    if (sb_q.size() != 0 || frm_cnt_o !== 16'(exp_cnt) || frm_busy_o !== 1'b0)
      $display("FAIL bp_done: got left=%0d cnt=%0d busy=%b expected left=0 cnt=%0d busy=0",
               sb_q.size(), frm_cnt_o, frm_busy_o, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_resync();
    @(negedge mclk);
    snap();
    sb_q.push_back({1'b1, 8'h7E});
    send(8'h55); send(8'h55); send(8'hAA); send(8'h01); send(8'h7E); send(8'h7F);
    exp_cnt++;
    repeat (4) @(negedge mclk);
    #2;
    total_cnt++;
    if (frm_cnt_o !== 16'(exp_cnt) || sb_q.size() != 0 || err_delta() !== 40'h0)
      $display("FAIL resync: got cnt=%0d left=%0d errs=%h expected cnt=%0d left=0 errs=0",
               frm_cnt_o, sb_q.size(), err_delta(), exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [38:0] outs;
    @(negedge mclk);
    snap();
    send(8'h55); send(8'hAA); send(8'h05); send(8'h01); send(8'h02);
    mrst_n = 1'b0;
    #1;
    outs = {frm_data_o, frm_valid_o, frm_last_o, frm_len_o, frm_busy_o, chk_err_o,
            len_err_o, tmo_err_o, drop_err_o, frm_cnt_o};
    total_cnt++;
    if (outs !== '0) $display("FAIL midreset_outs: got %h expected 0", outs);
    else pass_cnt++;
    repeat (2) @(negedge mclk);
    mrst_n  = 1'b1;
    exp_cnt = 0;
    @(negedge mclk);
    pl[0] = 8'h3C; pl[1] = 8'hC3; pl_n = 2;
    send_frame(8'h00);
    exp_cnt++;
    repeat (6) @(negedge mclk);
    #2;
    total_cnt++;
    if (frm_cnt_o !== 16'(exp_cnt) || sb_q.size() != 0 || err_delta() !== 40'h0)
      $display("FAIL midreset_recover: got cnt=%0d left=%0d errs=%h expected cnt=%0d left=0 errs=0",
               frm_cnt_o, sb_q.size(), err_delta(), exp_cnt);
    else pass_cnt++;
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_good_frame();
    test_chk_error();
    test_len_error();
    test_timeout();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    total_cnt++;
    if (n_multi != 0) $display("FAIL err_exclusive: got %0d overlapping cycles expected 0", n_multi);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
